// File: rtl/pixel_collector.sv
// Buffers 4-lane groups of (x, y, iter) results and serialises them, lane 1 first,
// as greyscale pixels on an AXI4-Stream video master with SOF (tuser) and EOL (tlast).
module pixel_collector #(
  parameter int DEPTH  = 4,
  parameter int ITER_W = 8
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [15:0]       X_size,
  input  logic [15:0]       Y_size,
  input  logic [ITER_W-1:0] max_iter,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [9:0]        in_x1,
  input  logic [9:0]        in_x2,
  input  logic [9:0]        in_x3,
  input  logic [9:0]        in_x4,
  input  logic [9:0]        in_y1,
  input  logic [9:0]        in_y2,
  input  logic [9:0]        in_y3,
  input  logic [9:0]        in_y4,
  input  logic [ITER_W-1:0] in_iter1,
  input  logic [ITER_W-1:0] in_iter2,
  input  logic [ITER_W-1:0] in_iter3,
  input  logic [ITER_W-1:0] in_iter4,
  output logic [23:0]       m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tuser,
  output logic              m_axis_tlast,
  output logic              frame_done
);

  localparam int LW = 20 + ITER_W;
  localparam int PW = $clog2(DEPTH);

  logic [LW-1:0]     mem [DEPTH][4];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [PW:0]       count;
  logic [1:0]        lane;
  logic              full;
  logic              empty;
  logic              push;
  logic              xfer;
  logic              pop;
  logic [LW-1:0]     cur;
  logic [9:0]        cur_x;
  logic [9:0]        cur_y;
  logic [ITER_W-1:0] cur_it;
  logic [7:0]        chan;
  logic              at_eol;
  logic              at_eof_row;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both
  // high; valid never waits on ready, and payload is held while valid && !ready.
  assign full     = (count == (PW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign in_ready = !full;
  assign push     = in_valid && !full;
  assign xfer     = m_axis_tvalid && m_axis_tready;
  assign pop      = xfer && (lane == 2'd3);

  assign cur    = mem[rd_ptr][lane];
  assign cur_x  = cur[LW-1 -: 10];
  assign cur_y  = cur[LW-11 -: 10];
  assign cur_it = cur[ITER_W-1:0];

  generate
    if (ITER_W >= 8) begin : g_chan_msb
      assign chan = cur_it[ITER_W-1 -: 8];
    end else begin : g_chan_pad
      assign chan = {cur_it, {(8-ITER_W){1'b0}}};
    end
  endgenerate

  assign at_eol     = ({6'd0, cur_x} == X_size - 16'd1);
  assign at_eof_row = ({6'd0, cur_y} == Y_size - 16'd1);

  // Outputs are gated by !empty so an idle port shows all-zero payload.
  assign m_axis_tvalid = !empty;
  assign m_axis_tdata  = (empty || cur_it >= max_iter) ? 24'h000000 : {chan, chan, chan};
  assign m_axis_tuser  = !empty && (cur_x == 10'd0) && (cur_y == 10'd0);
  assign m_axis_tlast  = !empty && at_eol;

  always_ff @(posedge aclk) begin
    if (push) begin
      mem[wr_ptr][0] <= {in_x1, in_y1, in_iter1};
      mem[wr_ptr][1] <= {in_x2, in_y2, in_iter2};
      mem[wr_ptr][2] <= {in_x3, in_y3, in_iter3};
      mem[wr_ptr][3] <= {in_x4, in_y4, in_iter4};
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      lane       <= 2'd0;
      frame_done <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count      <= count + (PW+1)'(push) - (PW+1)'(pop);
      if (xfer) lane <= lane + 2'd1;
      frame_done <= xfer && at_eol && at_eof_row;
    end
  end

endmodule

// File: tb/tb_pixel_collector.sv
// Directed bench for pixel_collector: scoreboard of expected beats, monitor on the
// opposite clock edge, and a single check task feeding the summary line.
module tb_pixel_collector;

  localparam int DEPTH  = 4;
  localparam int ITER_W = 8;

  logic              aclk = 1'b0;
  logic              aresetn = 1'b0;
  logic [15:0]       X_size = 16'd8;
  logic [15:0]       Y_size = 16'd2;
  logic [ITER_W-1:0] max_iter = 8'd255;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [3:0][9:0]   drv_x = '0;
  logic [3:0][9:0]   drv_y = '0;
  logic [3:0][7:0]   drv_it = '0;
  logic [23:0]       m_axis_tdata;
  logic              m_axis_tvalid;
  logic              m_axis_tready = 1'b0;
  logic              m_axis_tuser;
  logic              m_axis_tlast;
  logic              frame_done;

  // Scoreboard entry: {frame_end, tdata, tuser, tlast}
  logic [26:0] exp_q[$];
  logic [26:0] mon_e;
  logic        fd_exp = 1'b0;
  int          checks = 0;
  int          errors = 0;
  int          beats = 0;
  int          cyc = 0;

  pixel_collector #(.DEPTH(DEPTH), .ITER_W(ITER_W)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .X_size(X_size), .Y_size(Y_size), .max_iter(max_iter),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_x1(drv_x[0]), .in_x2(drv_x[1]), .in_x3(drv_x[2]), .in_x4(drv_x[3]),
    .in_y1(drv_y[0]), .in_y2(drv_y[1]), .in_y3(drv_y[2]), .in_y4(drv_y[3]),
    .in_iter1(drv_it[0]), .in_iter2(drv_it[1]), .in_iter3(drv_it[2]), .in_iter4(drv_it[3]),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast), .frame_done(frame_done)
  );

  // ---------------- clock / reset ----------------
  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc++;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [26:0] model(input logic [9:0] x, input logic [9:0] y,
                                        input logic [7:0] it);
    logic [23:0] d;
    logic tu, tl, fe;
    d  = (it >= max_iter) ? 24'h000000 : {it, it, it};
    tu = (x == 10'd0) && (y == 10'd0);
    tl = ({6'd0, x} == X_size - 16'd1);
    fe = tl && ({6'd0, y} == Y_size - 16'd1);
    return {fe, d, tu, tl};
  endfunction

  // Monitor: a transfer seen at the negedge completes on the next posedge.
  always @(negedge aclk) begin
    if (!aresetn) begin
      fd_exp = 1'b0;
    end else begin
      check("frame_done", {31'd0, frame_done}, {31'd0, fd_exp});
      fd_exp = 1'b0;
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 32'd1, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("beat", {6'd0, m_axis_tdata, m_axis_tuser, m_axis_tlast}, {6'd0, mon_e[25:0]});
          fd_exp = mon_e[26];
          beats++;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_group(input logic [3:0][9:0] xs, input logic [3:0][9:0] ys,
                            input logic [3:0][7:0] its, input bit use_model);
    bit ok;
    ok = 1'b0;
    drv_x = xs; drv_y = ys; drv_it = its; in_valid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge aclk);
      if (in_ready) begin
        ok = 1'b1;
        if (use_model)
          for (int l = 0; l < 4; l++) exp_q.push_back(model(xs[l], ys[l], its[l]));
      end
    end
    @(posedge aclk); #1;
    in_valid = 1'b0;
    if (!ok) check("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic make_group(input int g, output logic [3:0][9:0] xs,
                            output logic [3:0][9:0] ys, output logic [3:0][7:0] its);
    int p;
    for (int l = 0; l < 4; l++) begin
      p = g * 4 + l;
      xs[l]  = 10'(p % int'(X_size));
      ys[l]  = 10'(p / int'(X_size));
      its[l] = 8'((g * 37 + l * 61 + 5) % 256);
    end
  endtask

  task automatic wait_drain(input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge aclk);
      if (exp_q.size() == 0) done = 1'b1;
    end
    if (!done) check("drain_timeout", 32'd0, 32'd1);
    repeat (2) @(posedge aclk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  logic [3:0][9:0] gx, gy;
  logic [3:0][7:0] gi;
  int b0, t0;

  initial begin
    // 1: reset then idle
    repeat (3) begin
      @(negedge aclk);
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      check("rst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
      check("rst_tdata", {8'd0, m_axis_tdata}, 32'd0);
      check("rst_frame_done", {31'd0, frame_done}, 32'd0);
    end
    #2 aresetn = 1'b1;
    repeat (3) begin
      @(negedge aclk);
      check("idle_in_ready", {31'd0, in_ready}, 32'd1);
      check("idle_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
      check("idle_tdata", {8'd0, m_axis_tdata}, 32'd0);
    end
    @(posedge aclk); #1;

    // 2: single group, hand-computed beats
    m_axis_tready = 1'b1;
    exp_q.push_back({1'b0, 24'h0A0A0A, 1'b1, 1'b0});
    exp_q.push_back({1'b0, 24'h141414, 1'b0, 1'b0});
    exp_q.push_back({1'b0, 24'h000000, 1'b0, 1'b0});
    exp_q.push_back({1'b0, 24'h282828, 1'b0, 1'b0});
    push_group({10'd3, 10'd2, 10'd1, 10'd0}, '0, {8'd40, 8'd255, 8'd20, 8'd10}, 1'b0);
    @(negedge aclk);
    check("latency_tvalid", {31'd0, m_axis_tvalid}, 32'd1);
    wait_drain(20);

    // 3: end of line and end of frame
    exp_q.push_back({1'b0, 24'h010101, 1'b0, 1'b0});
    exp_q.push_back({1'b0, 24'h020202, 1'b0, 1'b0});
    exp_q.push_back({1'b0, 24'h030303, 1'b0, 1'b0});
    exp_q.push_back({1'b1, 24'h040404, 1'b0, 1'b1});
    push_group({10'd7, 10'd6, 10'd5, 10'd4}, {10'd1, 10'd1, 10'd1, 10'd1},
               {8'd4, 8'd3, 8'd2, 8'd1}, 1'b0);
    wait_drain(20);

    // 4: backpressure and full
    X_size = 16'd6; Y_size = 16'd100; max_iter = 8'd200;
    m_axis_tready = 1'b0;
    b0 = beats;
    for (int g = 0; g < 4; g++) begin
      make_group(g, gx, gy, gi);
      push_group(gx, gy, gi, 1'b1);
    end
    @(negedge aclk);
    check("full_in_ready", {31'd0, in_ready}, 32'd0);
    for (int g = 4; g < 6; g++) begin
      make_group(g, gx, gy, gi);
      drv_x = gx; drv_y = gy; drv_it = gi; in_valid = 1'b1;
      repeat (3) begin
        @(negedge aclk);
        check("full_block", {31'd0, in_ready}, 32'd0);
      end
    end
    @(posedge aclk); #1;
    in_valid = 1'b0;
    repeat (10) begin
      @(negedge aclk);
      check("hold_tvalid", {31'd0, m_axis_tvalid}, 32'd1);
      check("hold_beat", {6'd0, m_axis_tdata, m_axis_tuser, m_axis_tlast}, {6'd0, exp_q[0][25:0]});
    end
    @(posedge aclk); #1;
    m_axis_tready = 1'b1;
    repeat (4) begin
      @(negedge aclk);
      check("drain_in_ready_lo", {31'd0, in_ready}, 32'd0);
    end
    @(negedge aclk);
    check("drain_in_ready_hi", {31'd0, in_ready}, 32'd1);
    wait_drain(40);
    check("full_beats", 32'(beats - b0), 32'd16);

    // 5: concurrent push and pop, 20 groups
    b0 = beats;
    t0 = cyc;
    for (int g = 0; g < 20; g++) begin
      make_group(g, gx, gy, gi);
      push_group(gx, gy, gi, 1'b1);
    end
    wait_drain(200);
    check("stream_beats", 32'(beats - b0), 32'd80);
    check("throughput", {31'd0, (cyc - t0) <= 90}, 32'd1);

    // 6: reset mid-stream
    m_axis_tready = 1'b0;
    for (int g = 0; g < 2; g++) begin
      make_group(g + 30, gx, gy, gi);
      push_group(gx, gy, gi, 1'b1);
    end
    m_axis_tready = 1'b1;
    repeat (2) @(posedge aclk);
    #2 aresetn = 1'b0;
    exp_q.delete();
    #1;
    check("async_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    check("async_in_ready", {31'd0, in_ready}, 32'd1);
    check("async_tdata", {8'd0, m_axis_tdata}, 32'd0);
    repeat (2) @(posedge aclk);
    #2 aresetn = 1'b1;
    repeat (4) begin
      @(negedge aclk);
      check("no_stale_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    end
    @(posedge aclk); #1;
    b0 = beats;
    make_group(10, gx, gy, gi);
    push_group(gx, gy, gi, 1'b1);
    wait_drain(20);
    check("post_reset_beats", 32'(beats - b0), 32'd4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pixel_collector.md
Name: pixel_collector

Overview:
Return-side counterpart of the coordinate mapper in the pipelined fractal accelerator. It accepts groups of four per-pixel escape-iteration results from the four parallel compute lanes, together with each lane's x/y coordinate. It buffers the groups in a small FIFO and serialises them, lane 1 first, onto an AXI4-Stream video master port. The port emits greyscale RGB with start-of-frame (tuser) and end-of-line (tlast) markers.

Parameters:
DEPTH, 4, FIFO depth in 4-pixel groups; power of two, at least 2.
ITER_W, 8, width of an iteration count.

Ports:
aclk  in  1  clock
aresetn  in  1  reset
X_size  in  16  frame width in pixels; held static during a frame
Y_size  in  16  frame height in pixels; held static during a frame
max_iter  in  ITER_W  iteration limit; a pixel that reaches it is treated as inside the set
in_valid  in  1  group valid
in_ready  out  1  group accepted when in_valid and in_ready are both high
in_x1..in_x4  in  10 each  lane x coordinates
in_y1..in_y4  in  10 each  lane y coordinates
in_iter1..in_iter4  in  ITER_W each  lane iteration counts
m_axis_tdata  out  24  pixel colour {R,G,B}
m_axis_tvalid  out  1  AXI-Stream valid
m_axis_tready  in  1  AXI-Stream ready
m_axis_tuser  out  1  start of frame
m_axis_tlast  out  1  end of line
frame_done  out  1  one-cycle pulse after the final pixel of the frame is transferred

Behaviour:
- Clock and reset: single clock aclk. Reset aresetn is asynchronous, active-low.
- Reset state: FIFO empty, read and write pointers 0, lane counter 0. Outputs are in_ready=1, m_axis_tvalid=0, m_axis_tdata=0, m_axis_tuser=0, m_axis_tlast=0, frame_done=0.
- Reset mid-stream: everything clears immediately. Buffered and partially sent groups are discarded with no flush.
- Push: one FIFO entry per accepted group. An entry holds 4×(x, y, iter), i.e. 4×(20+ITER_W) bits.
- in_ready = !full. A group offered while full is not captured. There is no bypass path when full.
- Output source: driven combinationally from the FIFO head entry and a 2-bit lane counter (0→lane1 … 3→lane4).
- m_axis_tvalid = !empty.
- Transfer: a pixel transfers when tvalid and tready are both high. On transfer the lane counter increments. A transfer with lane counter = 3 pops the head entry and wraps the counter to 0.
- Latency: a group accepted on edge N presents lane 1 with tvalid=1 after edge N. Minimum 4 cycles per group at tready=1.
- Throughput: one pixel per cycle at sustained tready=1.
- Simultaneous push and pop: allowed. The count is unchanged and both pointers advance, modulo DEPTH, with no wrap corruption.
- Stability: while tvalid=1 and tready=0, tdata, tuser and tlast hold constant (AXI rule).
- Colour: if iter >= max_iter, tdata = 24'h000000. Otherwise each channel is the 8 MSBs of iter; if ITER_W < 8, iter is left-aligned and zero-padded. tdata = {c,c,c}.
- tuser = 1 iff the current lane's x==0 and y==0.
- tlast = 1 iff the current lane's x == X_size-1, compared as 16 bits with x zero-extended.
- frame_done: pulses 1 cycle after the transfer of the pixel with x==X_size-1 and y==Y_size-1.
- Coordinates are passed through unchecked. Ordering across groups is the producer's responsibility.
- X_size is not required to be a multiple of 4. tlast is evaluated per pixel, so it may appear on any lane.

Test Plan:
1. Reset then idle. Hold aresetn=0 for 3 cycles, then release with in_valid=0. Required: in_ready=1, m_axis_tvalid=0, tdata=0, frame_done=0 throughout.
2. Single group, tready=1, X_size=8, Y_size=2, max_iter=255. Push x=0..3, y=0, iter={10,20,255,40}. Required: four consecutive beats, tdata = 0A0A0A, 141414, 000000, 282828; tuser=1 on beat 1 only; tlast=0 on all beats.
3. End of line and end of frame, same sizes as scenario 2. Push x=4..7, y=1, iters 1..4. Required: tlast=1 only on the x=7 beat; frame_done=1 for exactly one cycle, one cycle after that beat.
4. Backpressure and full. DEPTH=4, tready=0, push 6 groups. Required: in_ready drops to 0 after the 4th acceptance and groups 5 and 6 are not taken. Head beat holds stable 10 cycles. After tready=1, 16 beats drain in order and in_ready returns to 1 after the first pop.
5. Concurrent push and pop. Stream continuous groups with tready=1 for 20 groups. Required: 80 beats in exact input order, no loss or duplication, pointers wrap cleanly.
6. Reset mid-stream. Assert aresetn=0 after the 2nd beat of a group, with 2 groups buffered. Required: tvalid falls to 0 asynchronously; after release, no stale beats appear; the next pushed group starts at lane 1.
